// File: rtl/bcd_7seg_scan_4dig.sv
// Purpose: multiplexed 4-digit common-anode 7-seg driver with shadowed BCD, dead time, zero blanking, err flag.
// Latency: outputs are registered, 1 cycle behind the scan state and shadow; err 1 cycle behind shadow.
// Backpressure: none; load is a free-running capture strobe, en freezes the scan and darkens the display.
module bcd_7seg_scan_4dig #(
    parameter int PRESCALE   = 50000,
    parameter int DEAD       = 4,
    parameter int BLANK_LEAD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        load,
    input  logic        en,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        err
);

    localparam int            CW      = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [15:0]   shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          err_q, err_d;

    logic [3:0]    nib;
    logic          upper_zero;
    logic          dark;

    // Active-low segment code {g,f,e,d,c,b,a}; anything above 9 renders 'E'.
    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = 7'b0000110;
        endcase
        return c;
    endfunction

    // Next-state for shadow, scan counters, error flag and the registered display outputs.
    always_comb begin
        shadow_d = load ? bcd : shadow_q;

        cnt_d = cnt_q;
        dig_d = dig_q;
        if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                dig_d = dig_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        err_d = (shadow_q[15:12] > 4'd9) || (shadow_q[11:8] > 4'd9) ||
                (shadow_q[7:4]   > 4'd9) || (shadow_q[3:0]  > 4'd9);

        nib = shadow_q[{dig_q, 2'b00} +: 4];

        // Digit 0 is never a leading zero, so "0" still shows for an all-zero word.
        case (dig_q)
            2'd1:    upper_zero = (shadow_q[15:8] == 8'h00);
            2'd2:    upper_zero = (shadow_q[15:12] == 4'h0);
            2'd3:    upper_zero = 1'b1;
            default: upper_zero = 1'b0;
        endcase

        // Anodes stay off for the first DEAD cycles of each slot to hide segment transitions.
        dark = !en || (32'(cnt_q) < DEAD);

        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!dark) begin
            an_d = ~(4'b0001 << dig_q);
            dp_d = ~dp_in[dig_q];
            if ((BLANK_LEAD != 0) && upper_zero && (nib == 4'd0)) begin
                seg_d = 7'h7F;
            end else begin
                seg_d = seg_code(nib);
            end
        end
    end

    // State and output registers; reset darkens the display without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            dig_q    <= '0;
            an_q     <= 4'b1111;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            err_q    <= err_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_7seg_scan_4dig.sv
module tb_bcd_7seg_scan_4dig;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd;
    logic        load;
    logic        en;
    logic [3:0]  dp_in;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic        err0, err1;

    int checks = 0;
    int errors = 0;

    // Scan position model: number of enabled edges since reset, mod one refresh period (32).
    int   pos     = 0;
    int   out_pos = 0;
    logic out_en  = 1'b0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    bcd_7seg_scan_4dig #(.PRESCALE(8), .DEAD(2), .BLANK_LEAD(1)) dut (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .en(en), .dp_in(dp_in),
        .an(an0), .seg(seg0), .dp(dp0), .err(err0)
    );

    bcd_7seg_scan_4dig #(.PRESCALE(8), .DEAD(2), .BLANK_LEAD(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load), .en(en), .dp_in(dp_in),
        .an(an1), .seg(seg1), .dp(dp1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; afterwards the outputs reflect the scan state and inputs in force before the edge.
    task automatic tick();
        out_pos = pos;
        out_en  = en;
        if (en) pos = (pos + 1) % 32;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] exp_an();
        if (!out_en || (out_pos % 8) < 2) return 4'b1111;
        return an_tab[out_pos / 8];
    endfunction

    task automatic test_reset();
        checks++; if (an0 !== 4'b1111) begin errors++; $display("FAIL rst_an got %b exp 1111", an0); end
        checks++; if (seg0 !== 7'h7F) begin errors++; $display("FAIL rst_seg got %b exp 1111111", seg0); end
        checks++; if (dp0 !== 1'b1) begin errors++; $display("FAIL rst_dp got %b exp 1", dp0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err0); end
        rst_n = 1'b1; pos = 0;
        en = 1'b1; bcd = 16'h00A5; load = 1'b1;
        tick();
        load = 1'b0;
        tick(); tick(); tick();
        checks++; if (an0 !== 4'b1110) begin errors++; $display("FAIL pre_rst_an got %b exp 1110", an0); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL pre_rst_err got %b exp 1", err0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an0 !== 4'b1111) begin errors++; $display("FAIL async_rst_an got %b exp 1111", an0); end
        checks++; if (seg0 !== 7'h7F) begin errors++; $display("FAIL async_rst_seg got %b exp 1111111", seg0); end
        checks++; if (dp0 !== 1'b1) begin errors++; $display("FAIL async_rst_dp got %b exp 1", dp0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL async_rst_err got %b exp 0", err0); end
        @(posedge clk); @(negedge clk);
        checks++; if (an0 !== 4'b1111) begin errors++; $display("FAIL held_rst_an got %b exp 1111", an0); end
        rst_n = 1'b1; pos = 0;
        tick(); tick();
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL post_rst_err got %b exp 0", err0); end
        checks++; if (an0 !== 4'b1111) begin errors++; $display("FAIL post_rst_dark got %b exp 1111", an0); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4];
        int on_cnt [4];
        int dark_cnt;
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        on_cnt = '{0, 0, 0, 0};
        dark_cnt = 0;
        while ((pos % 32) != 31) tick();
        bcd = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if (an0 !== exp_an()) begin errors++; $display("FAIL scan_an pos %0d got %b exp %b", out_pos, an0, exp_an()); end
            if (exp_an() == 4'b1111) dark_cnt++;
            else begin
                on_cnt[out_pos / 8]++;
                checks++;
                if (seg0 !== exp_seg[out_pos / 8]) begin errors++; $display("FAIL scan_seg pos %0d got %b exp %b", out_pos, seg0, exp_seg[out_pos / 8]); end
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (on_cnt[d] != 6) begin errors++; $display("FAIL slot_len dig %0d got %0d exp 6", d, on_cnt[d]); end
        end
        checks++; if (dark_cnt != 8) begin errors++; $display("FAIL dead_cycles got %0d exp 8", dark_cnt); end
    endtask

    task automatic test_blank();
        logic [6:0] e0 [4];
        logic [6:0] e1 [4];
        for (int v = 0; v < 2; v++) begin
            if (v == 0) begin
                bcd = 16'h0007;
                e0 = '{7'b1111000, 7'h7F, 7'h7F, 7'h7F};
                e1 = '{7'b1111000, 7'b1000000, 7'b1000000, 7'b1000000};
            end else begin
                bcd = 16'h0000;
                e0 = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
                e1 = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
            end
            load = 1'b1;
            tick();
            load = 1'b0;
            for (int i = 0; i < 32; i++) begin
                tick();
                if (exp_an() != 4'b1111) begin
                    checks++;
                    if (seg0 !== e0[out_pos / 8]) begin errors++; $display("FAIL blank_seg v%0d pos %0d got %b exp %b", v, out_pos, seg0, e0[out_pos / 8]); end
                    checks++;
                    if (seg1 !== e1[out_pos / 8]) begin errors++; $display("FAIL noblank_seg v%0d pos %0d got %b exp %b", v, out_pos, seg1, e1[out_pos / 8]); end
                end
            end
        end
    endtask

    task automatic test_invalid();
        logic [6:0] e0 [4];
        logic [6:0] e1 [4];
        e0 = '{7'b0010010, 7'b0000110, 7'h7F, 7'h7F};
        e1 = '{7'b0010010, 7'b0000110, 7'b1000000, 7'b1000000};
        bcd = 16'h00A5; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_lag got %b exp 0", err0); end
        tick();
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err0); end
        for (int i = 0; i < 32; i++) begin
            tick();
            if (exp_an() != 4'b1111) begin
                checks++;
                if (seg0 !== e0[out_pos / 8]) begin errors++; $display("FAIL inv_seg pos %0d got %b exp %b", out_pos, seg0, e0[out_pos / 8]); end
                checks++;
                if (seg1 !== e1[out_pos / 8]) begin errors++; $display("FAIL inv_seg_nb pos %0d got %b exp %b", out_pos, seg1, e1[out_pos / 8]); end
            end
        end
        bcd = 16'h0005; load = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", err0); end
        tick();
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err0); end
    endtask

    task automatic test_en_dp();
        while (pos != 13) tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (an0 !== 4'b1111) begin errors++; $display("FAIL en_off_an cyc %0d got %b exp 1111", i, an0); end
        end
        en = 1'b1;
        tick();
        checks++; if (an0 !== 4'b1101) begin errors++; $display("FAIL en_resume_an got %b exp 1101", an0); end
        tick(); tick();
        checks++; if (an0 !== 4'b1101) begin errors++; $display("FAIL en_resume_last got %b exp 1101", an0); end
        tick();
        checks++; if (an0 !== 4'b1111) begin errors++; $display("FAIL en_resume_dead got %b exp 1111", an0); end
        dp_in = 4'b0100;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if (an0 !== exp_an()) begin errors++; $display("FAIL dp_an pos %0d got %b exp %b", out_pos, an0, exp_an()); end
            checks++;
            if (dp0 !== ((exp_an() == 4'b1011) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL dp pos %0d got %b exp %b", out_pos, dp0, (exp_an() == 4'b1011) ? 1'b0 : 1'b1);
            end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_boundary();
        while ((pos % 8) != 7) tick();
        bcd = 16'h9999; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (an0 !== exp_an()) begin errors++; $display("FAIL bnd_an pos %0d got %b exp %b", out_pos, an0, exp_an()); end
            if (exp_an() != 4'b1111) begin
                checks++;
                if (seg0 !== 7'b0010000) begin errors++; $display("FAIL bnd_seg pos %0d got %b exp 0010000", out_pos, seg0); end
            end
            checks++;
            if (err0 !== 1'b0) begin errors++; $display("FAIL bnd_err pos %0d got %b exp 0", out_pos, err0); end
        end
    endtask

    initial begin
        rst_n = 1'b0; bcd = '0; load = 1'b0; en = 1'b0; dp_in = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_scan();
        test_blank();
        test_invalid();
        test_en_dp();
        test_boundary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
